flow_key_extract: RTL and testbench



---
 rtl/flow_key_extract.sv | 183 ++++++++++++++++++
 tb/tb_flow_key_extract.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flow_key_extract.sv
// Forwards parser metadata flits with one register stage and extracts the IPv4 5-tuple plus an XOR-fold hash.
// Optional build macro FLOW_KEY_SYMMETRIC_EN canonicalises src/dst so both flow directions share one key.
`timescale 1ns/1ps
module flow_key_extract #(
  parameter int HASH_W    = 9,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 metadata_in_valid,
  input  logic [133:0]         metadata_in,
  output logic                 ready_out,
  output logic                 metadata_out_valid,
  output logic [133:0]         metadata_out,
  input  logic                 ready_in,
  output logic                 key_out_valid,
  output logic [103:0]         key_out,
  output logic [HASH_W-1:0]    hash_out,
  input  logic                 key_out_ready,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int KEY_W  = 104;
  localparam int NSLICE = (KEY_W + HASH_W - 1) / HASH_W;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_HDR       = 2'd1;
  localparam logic [1:0] ST_WAIT_TAIL = 2'd2;

  localparam logic [1:0] MK_HEAD = 2'b01;
  localparam logic [1:0] MK_TAIL = 2'b10;

  function automatic logic [HASH_W-1:0] fold_hash(input logic [KEY_W-1:0] k);
    logic [HASH_W-1:0] h;
    logic [KEY_W-1:0]  t;
    h = '0;
    t = k;
    for (int s = 0; s < NSLICE; s++) begin
      h = h ^ t[HASH_W-1:0];
      t = t >> HASH_W;
    end
    return h;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
    return (c == '1) ? c : c + ERR_CNT_W'(1);
  endfunction

`ifdef FLOW_KEY_SYMMETRIC_EN
  function automatic logic [KEY_W-1:0] canon_key(input logic [KEY_W-1:0] k);
    logic [47:0] src_ep;
    logic [47:0] dst_ep;
    src_ep = {k[103:72], k[39:24]};
    dst_ep = {k[71:40],  k[23:8]};
    if (src_ep > dst_ep)
      return {k[71:40], k[103:72], k[23:8], k[39:24], k[7:0]};
    return k;
  endfunction
`endif

  logic [1:0]  state;
  logic [1:0]  idx;
  logic        accept_p0;
  logic        is_head_p0;
  logic        is_tail_p0;
  logic        cap_p0;
  logic [KEY_W-1:0] key_p0;

  logic        ipv4_ok;
  logic        l4_ok;
  logic [7:0]  proto_r;
  logic [31:0] src_ip_r;
  logic [15:0] dst_hi_r;

  logic             vld_p1;
  logic [KEY_W-1:0] key_p1;

  assign ready_out  = ready_in & (~key_out_valid | key_out_ready);
  assign accept_p0  = metadata_in_valid & ready_out;
  assign is_head_p0 = (metadata_in[133:132] == MK_HEAD);
  assign is_tail_p0 = (metadata_in[133:132] == MK_TAIL);
  assign cap_p0     = accept_p0 & (state == ST_HDR) & (idx == 2'd3) & ~is_head_p0 & ipv4_ok & l4_ok;

`ifdef FLOW_KEY_SYMMETRIC_EN
  assign key_p0 = canon_key({src_ip_r, dst_hi_r, metadata_in[127:112],
                             metadata_in[111:96], metadata_in[95:80], proto_r});
`else
  assign key_p0 = {src_ip_r, dst_hi_r, metadata_in[127:112],
                   metadata_in[111:96], metadata_in[95:80], proto_r};
`endif

  // Stage 0: packet framing FSM and error counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      idx     <= 2'd0;
      err_cnt <= '0;
    end else if (accept_p0) begin
      if (is_head_p0) begin
        if (state != ST_IDLE)
          err_cnt <= sat_inc(err_cnt);
        state <= ST_HDR;
        idx   <= 2'd1;
      end else begin
        case (state)
          ST_IDLE: err_cnt <= sat_inc(err_cnt);
          ST_HDR: begin
            idx <= idx + 2'd1;
            if (is_tail_p0) begin
              state <= ST_IDLE;
              idx   <= 2'd0;
            end else if (idx == 2'd3) begin
              state <= ST_WAIT_TAIL;
            end
          end
          ST_WAIT_TAIL: begin
            if (is_tail_p0) begin
              state <= ST_IDLE;
              idx   <= 2'd0;
            end
          end
          default: begin
            state <= ST_IDLE;
            idx   <= 2'd0;
          end
        endcase
      end
    end
  end

  // Header fields are always rewritten by flits 1 and 2 before flit 3 can use them
  always_ff @(posedge clk) begin
    if (accept_p0 && state == ST_HDR && !is_head_p0) begin
      if (idx == 2'd1)
        ipv4_ok <= (metadata_in[31:16] == 16'h0800);
      if (idx == 2'd2) begin
        proto_r  <= metadata_in[71:64];
        src_ip_r <= metadata_in[47:16];
        dst_hi_r <= metadata_in[15:0];
        l4_ok    <= (metadata_in[71:64] == 8'd6) || (metadata_in[71:64] == 8'd17);
      end
    end
  end

  // Pass-through register
  always_ff @(posedge clk) begin
    if (reset) begin
      metadata_out_valid <= 1'b0;
      metadata_out       <= '0;
    end else if (accept_p0) begin
      metadata_out_valid <= 1'b1;
      metadata_out       <= metadata_in;
    end else if (ready_in) begin
      metadata_out_valid <= 1'b0;
    end
  end

  // Stage 1: key capture
  always_ff @(posedge clk) begin
    if (reset)
      vld_p1 <= 1'b0;
    else
      vld_p1 <= cap_p0;
    if (cap_p0)
      key_p1 <= key_p0;
  end

  // Stage 2: hash and output slot; a new key overrides a same-cycle accept
  always_ff @(posedge clk) begin
    if (reset) begin
      key_out_valid <= 1'b0;
      key_out       <= '0;
      hash_out      <= '0;
    end else if (vld_p1) begin
      key_out_valid <= 1'b1;
      key_out       <= key_p1;
      hash_out      <= fold_hash(key_p1);
    end else if (key_out_ready) begin
      key_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_flow_key_extract.sv
// Scoreboard bench for flow_key_extract: directed packets, expected flits and keys queued at issue time.
`timescale 1ns/1ps
module tb_flow_key_extract;
  localparam int HASH_W    = 9;
  localparam int ERR_CNT_W = 16;
  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] BODY = 2'b11;
  localparam logic [1:0] TAIL = 2'b10;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 metadata_in_valid;
  logic [133:0]         metadata_in;
  logic                 ready_out;
  logic                 metadata_out_valid;
  logic [133:0]         metadata_out;
  logic                 ready_in;
  logic                 key_out_valid;
  logic [103:0]         key_out;
  logic [HASH_W-1:0]    hash_out;
  logic                 key_out_ready;
  logic [ERR_CNT_W-1:0] err_cnt;

  always #5 clk = ~clk;

  flow_key_extract #(.HASH_W(HASH_W), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk(clk), .reset(reset),
    .metadata_in_valid(metadata_in_valid), .metadata_in(metadata_in), .ready_out(ready_out),
    .metadata_out_valid(metadata_out_valid), .metadata_out(metadata_out), .ready_in(ready_in),
    .key_out_valid(key_out_valid), .key_out(key_out), .hash_out(hash_out),
    .key_out_ready(key_out_ready), .err_cnt(err_cnt)
  );

  logic [133:0] flit_q[$];
  logic [103:0] key_q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [HASH_W-1:0] ref_hash(input logic [103:0] k);
    logic [HASH_W-1:0] h;
    int j;
    h = '0;
    j = 0;
    for (int b = 0; b < 104; b++) begin
      h = h ^ (HASH_W'(k[b]) << j);
      j = (j == HASH_W - 1) ? 0 : j + 1;
    end
    return h;
  endfunction

  task automatic check(input string nm, input logic [133:0] act, input logic [133:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout/unexpected, expected event", nm);
  endtask

  task automatic send_flit(input logic [1:0] mk, input logic [127:0] d);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    metadata_in_valid = 1'b1;
    metadata_in = {mk, 4'h0, d};
    while (!acc && guard < 500) begin
      @(negedge clk);
      acc = ready_out;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) fail_now("flit_accept_timeout");
    else flit_q.push_back({mk, 4'h0, d});
    metadata_in_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [15:0] eth, input logic [7:0] proto,
                          input logic [31:0] sip, input logic [31:0] dip,
                          input logic [15:0] sp, input logic [15:0] dp,
                          input int nflits, input bit has_key, input logic [103:0] exp_key);
    logic [127:0] d;
    logic [1:0] mk;
    for (int i = 0; i < nflits; i++) begin
      mk = (i == 0) ? HEAD : (i == nflits - 1) ? TAIL : BODY;
      d = {4{32'h5A5A_0000 | 32'(i)}};
      case (i)
        1: d[31:16] = eth;
        2: begin d[71:64] = proto; d[47:16] = sip; d[15:0] = dip[31:16]; end
        3: begin d[127:112] = dip[15:0]; d[111:96] = sp; d[95:80] = dp; end
        default: ;
      endcase
      send_flit(mk, d);
      if (i == 3 && has_key) key_q.push_back(exp_key);
    end
  endtask

  task automatic wait_key(input string nm);
    int g;
    g = 0;
    @(negedge clk);
    while (!key_out_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!key_out_valid) fail_now(nm);
  endtask

  // Monitor: each negedge with valid & ready is exactly one transfer on the next edge
  initial begin
    logic [133:0] ef;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (metadata_out_valid && ready_in) begin
          if (flit_q.size() == 0) fail_now("flit_unexpected");
          else begin
            ef = flit_q.pop_front();
            check("flit", metadata_out, ef);
          end
        end
        if (key_out_valid) begin
          if (key_q.size() == 0) fail_now("key_unexpected");
          else begin
            check("key", 134'(key_out), 134'(key_q[0]));
            check("hash", 134'(hash_out), 134'(ref_hash(key_q[0])));
            if (key_out_ready) void'(key_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    metadata_in_valid = 1'b0;
    metadata_in = '0;
    ready_in = 1'b1;
    key_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_md_valid", 134'(metadata_out_valid), 134'(0));
    check("rst_md", metadata_out, 134'(0));
    check("rst_key_valid", 134'(key_out_valid), 134'(0));
    check("rst_key", 134'(key_out), 134'(0));
    check("rst_hash", 134'(hash_out), 134'(0));
    check("rst_err", 134'(err_cnt), 134'(0));
    @(posedge clk); #1;

    // TCP 5-flit packet, key held so its constants can be checked directly
    send_pkt(16'h0800, 8'h06, 32'h0000_1111, 32'h2222_3333, 16'h0001, 16'h0002, 5,
             1'b1, 104'h00001111_22223333_0001_0002_06);
    wait_key("tcp_key_timeout");
    check("tcp_key_const", 134'(key_out), 134'(104'h00001111_22223333_0001_0002_06));
    check("tcp_hash_const", 134'(hash_out), 134'(9'h13B));
    check("tcp_err", 134'(err_cnt), 134'(0));
    @(posedge clk); #1 key_out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    // UDP 6-flit packet with downstream backpressure mid-packet
    fork
      send_pkt(16'h0800, 8'h11, 32'h0000_1111, 32'h2222_3333, 16'h0001, 16'h0002, 6,
               1'b1, 104'h00001111_22223333_0001_0002_11);
      begin
        repeat (2) @(posedge clk);
        #1 ready_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 ready_in = 1'b1;
      end
    join
    repeat (5) @(posedge clk); #1;

    // Key slot stalled: ready_out must drop, second packet waits
    key_out_ready = 1'b0;
    send_pkt(16'h0800, 8'h06, 32'h0101_0101, 32'h0202_0202, 16'h0100, 16'h0200, 5,
             1'b1, 104'h01010101_02020202_0100_0200_06);
    wait_key("stall_key_timeout");
    for (int i = 0; i < 10; i++) begin
      check("stall_ready_out", 134'(ready_out), 134'(0));
      @(negedge clk);
    end
    fork
      send_pkt(16'h0800, 8'h11, 32'h0303_0303, 32'h0404_0404, 16'h0300, 16'h0400, 4,
               1'b1, 104'h03030303_04040404_0300_0400_11);
      begin
        repeat (3) @(posedge clk);
        #1 check("stall_ready_out2", 134'(ready_out), 134'(0));
        key_out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk); #1;

    // Head mid-packet abandons the partial one; stray tail in IDLE
    send_flit(HEAD, 128'h0);
    send_flit(BODY, 128'h0800_0000);
    send_flit(BODY, {56'h0, 8'h06, 16'h0, 32'h0A0B_0C0D, 16'h0E0F});
    send_pkt(16'h0800, 8'h06, 32'h0000_1111, 32'h2222_3333, 16'h0001, 16'h0002, 5,
             1'b1, 104'h00001111_22223333_0001_0002_06);
    check("err_head_restart", 134'(err_cnt), 134'(1));
    send_flit(TAIL, 128'h1234);
    @(negedge clk);
    check("err_stray_tail", 134'(err_cnt), 134'(2));
    @(posedge clk); #1;

    // Non-IPv4 and runt: forwarded, no key, no error
    send_pkt(16'h86DD, 8'h06, 32'h0000_1111, 32'h2222_3333, 16'h0001, 16'h0002, 5, 1'b0, '0);
    send_pkt(16'h0800, 8'h06, 32'h0000_1111, 32'h2222_3333, 16'h0001, 16'h0002, 3, 1'b0, '0);
    send_pkt(16'h0800, 8'h01, 32'h0000_1111, 32'h2222_3333, 16'h0001, 16'h0002, 5, 1'b0, '0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("err_unchanged", 134'(err_cnt), 134'(2));
    @(posedge clk); #1;

    // Both directions of one flow
`ifdef FLOW_KEY_SYMMETRIC_EN
    send_pkt(16'h0800, 8'h06, 32'h0A00_0001, 32'h0A00_0002, 16'h1234, 16'h0050, 4,
             1'b1, 104'h0A000001_0A000002_1234_0050_06);
    send_pkt(16'h0800, 8'h06, 32'h0A00_0002, 32'h0A00_0001, 16'h0050, 16'h1234, 4,
             1'b1, 104'h0A000001_0A000002_1234_0050_06);
`else
    send_pkt(16'h0800, 8'h06, 32'h0A00_0001, 32'h0A00_0002, 16'h1234, 16'h0050, 4,
             1'b1, 104'h0A000001_0A000002_1234_0050_06);
    send_pkt(16'h0800, 8'h06, 32'h0A00_0002, 32'h0A00_0001, 16'h0050, 16'h1234, 4,
             1'b1, 104'h0A000002_0A000001_0050_1234_06);
`endif
    repeat (5) @(posedge clk); #1;

    // Reset mid-packet: partial packet discarded, counter cleared, new head is not an error
    send_flit(HEAD, 128'h0);
    send_flit(BODY, 128'h0800_0000);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    send_pkt(16'h0800, 8'h11, 32'h0505_0505, 32'h0606_0606, 16'h0500, 16'h0600, 5,
             1'b1, 104'h05050505_06060606_0500_0600_11);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("reset_err", 134'(err_cnt), 134'(0));
    check("flit_q_drained", 134'(flit_q.size()), 134'(0));
    check("key_q_drained", 134'(key_q.size()), 134'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
